mc_sequencer: RTL and testbench

MC_SEQUENCER -- requirements
Module: mc_sequencer

---
 rtl/mc_sequencer.sv | 158 +++++++++++++++
 tb/tb_mc_sequencer.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mc_sequencer.sv
// Microcoded instruction sequencer: fetches 16-bit instructions, decodes them and
// drives register-file, ALU and data-memory controls for each instruction class.
module mc_sequencer #(
  parameter int PC_W = 16,
  parameter int DA_W = 8
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic [15:0]     i_data,
  input  logic            i_ready,
  input  logic            d_ready,
  input  logic            rf_rp_zero,
  output logic [PC_W-1:0] i_addr,
  output logic            i_rd,
  output logic [DA_W-1:0] d_addr,
  output logic            d_rd,
  output logic            d_wr,
  output logic [7:0]      rf_w_data,
  output logic [1:0]      rf_sel,
  output logic [3:0]      rf_w_addr,
  output logic [3:0]      rf_rp_addr,
  output logic [3:0]      rf_rq_addr,
  output logic            rf_w_wr,
  output logic            rf_rp_rd,
  output logic            rf_rq_rd,
  output logic [1:0]      alu_op,
  output logic            halted,
  output logic [3:0]      state
);

  typedef enum logic [3:0] {
    S_INIT   = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_LOAD   = 4'd3,
    S_STORE  = 4'd4,
    S_ADD    = 4'd5,
    S_LDC    = 4'd6,
    S_SUB    = 4'd7,
    S_JZ     = 4'd8,
    S_JMP    = 4'd9,
    S_HALT   = 4'd10
  } state_t;

  state_t          st;
  logic [PC_W-1:0] pc;
  logic [15:0]     ir;
  logic [3:0]      op, ra, rb, rc;
  logic [7:0]      imm;
  logic [PC_W-1:0] imm_ext;

  assign op      = ir[15:12];
  assign ra      = ir[11:8];
  assign rb      = ir[7:4];
  assign rc      = ir[3:0];
  assign imm     = ir[7:0];
  assign imm_ext = PC_W'($signed(imm));
  assign i_addr  = pc;
  assign state   = st;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      st <= S_INIT;
      pc <= '0;
      ir <= '0;
    end else begin
      case (st)
        S_INIT:  st <= S_FETCH;
        S_FETCH: begin
          if (i_ready) begin
            ir <= i_data;
            pc <= pc + PC_W'(1);
            st <= S_DECODE;
          end
        end
        S_DECODE: begin
          case (op)
            4'd0:    st <= S_LOAD;
            4'd1:    st <= S_STORE;
            4'd2:    st <= S_ADD;
            4'd3:    st <= S_LDC;
            4'd4:    st <= S_SUB;
            4'd5:    st <= S_JZ;
            4'd6:    st <= S_JMP;
            4'd7:    st <= S_HALT;
            default: st <= S_FETCH;
          endcase
        end
        S_LOAD, S_STORE: if (d_ready) st <= S_FETCH;
        S_ADD, S_LDC, S_SUB: st <= S_FETCH;
        S_JZ:    st <= rf_rp_zero ? S_JMP : S_FETCH;
        // PC already points past the jump, so subtract one to make the offset
        // relative to the jump instruction itself.
        S_JMP: begin
          pc <= pc + imm_ext - PC_W'(1);
          st <= S_FETCH;
        end
        S_HALT:  st <= S_HALT;
        default: st <= S_FETCH;
      endcase
    end
  end

  always_comb begin
    i_rd       = 1'b0;
    d_addr     = '0;
    d_rd       = 1'b0;
    d_wr       = 1'b0;
    rf_w_data  = '0;
    rf_sel     = 2'b00;
    rf_w_addr  = '0;
    rf_rp_addr = '0;
    rf_rq_addr = '0;
    rf_w_wr    = 1'b0;
    rf_rp_rd   = 1'b0;
    rf_rq_rd   = 1'b0;
    alu_op     = 2'b00;
    halted     = 1'b0;
    case (st)
      S_FETCH: i_rd = 1'b1;
      S_LOAD: begin
        d_rd      = 1'b1;
        d_addr    = ir[DA_W-1:0];
        rf_sel    = 2'b01;
        rf_w_addr = ra;
        rf_w_wr   = d_ready;
      end
      S_STORE: begin
        d_wr       = 1'b1;
        d_addr     = ir[DA_W-1:0];
        rf_rp_addr = ra;
        rf_rp_rd   = 1'b1;
      end
      S_ADD, S_SUB: begin
        rf_rp_addr = rb;
        rf_rq_addr = rc;
        rf_rp_rd   = 1'b1;
        rf_rq_rd   = 1'b1;
        rf_w_addr  = ra;
        rf_w_wr    = 1'b1;
        alu_op     = (st == S_ADD) ? 2'b01 : 2'b10;
      end
      S_LDC: begin
        rf_sel    = 2'b10;
        rf_w_data = imm;
        rf_w_addr = ra;
        rf_w_wr   = 1'b1;
      end
      S_JZ: begin
        rf_rp_addr = ra;
        rf_rp_rd   = 1'b1;
      end
      S_HALT:  halted = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mc_sequencer.sv
// Self-checking bench for mc_sequencer: per-instruction vector table through a
// scoreboard queue, plus hand-written multi-cycle sequences.
module tb_mc_sequencer;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [15:0] i_data;
  logic        i_ready, d_ready, rf_rp_zero;
  logic [15:0] i_addr;
  logic        i_rd;
  logic [7:0]  d_addr;
  logic        d_rd, d_wr;
  logic [7:0]  rf_w_data;
  logic [1:0]  rf_sel;
  logic [3:0]  rf_w_addr, rf_rp_addr, rf_rq_addr;
  logic        rf_w_wr, rf_rp_rd, rf_rq_rd;
  logic [1:0]  alu_op;
  logic        halted;
  logic [3:0]  state;

  logic [15:0] imem [0:65535];
  assign i_data = imem[i_addr];

  always #5 clk = ~clk;

  mc_sequencer #(.PC_W(16), .DA_W(8)) dut (
    .clk(clk), .reset_n(reset_n), .i_data(i_data), .i_ready(i_ready),
    .d_ready(d_ready), .rf_rp_zero(rf_rp_zero), .i_addr(i_addr), .i_rd(i_rd),
    .d_addr(d_addr), .d_rd(d_rd), .d_wr(d_wr), .rf_w_data(rf_w_data),
    .rf_sel(rf_sel), .rf_w_addr(rf_w_addr), .rf_rp_addr(rf_rp_addr),
    .rf_rq_addr(rf_rq_addr), .rf_w_wr(rf_w_wr), .rf_rp_rd(rf_rp_rd),
    .rf_rq_rd(rf_rq_rd), .alu_op(alu_op), .halted(halted), .state(state)
  );

  typedef struct packed {
    logic       d_rd, d_wr;
    logic [7:0] d_addr, w_data;
    logic [1:0] sel;
    logic [3:0] w_addr, rp_addr, rq_addr;
    logic       w_wr, rp_rd, rq_rd;
    logic [1:0] alu;
    logic       halted, i_rd;
  } outs_t;

  typedef struct {
    logic [15:0] instr;
    logic        zero;
    logic [3:0]  st;
    outs_t       exp;
  } vec_t;

  outs_t act;
  assign act = {d_rd, d_wr, d_addr, rf_w_data, rf_sel, rf_w_addr, rf_rp_addr,
                rf_rq_addr, rf_w_wr, rf_rp_rd, rf_rq_rd, alu_op, halted, i_rd};

  int checks = 0;
  int failures = 0;
  vec_t vecs[$];
  vec_t sb[$];

  function automatic outs_t mk(input logic rd, input logic wr, input logic [7:0] da,
                               input logic [7:0] wd, input logic [1:0] sel,
                               input logic [3:0] wa, input logic [3:0] pa,
                               input logic [3:0] qa, input logic ww, input logic pr,
                               input logic qr, input logic [1:0] alu, input logic h);
    outs_t o;
    o = {rd, wr, da, wd, sel, wa, pa, qa, ww, pr, qr, alu, h, 1'b0};
    return o;
  endfunction

  function automatic logic [15:0] jmp_target(input logic [15:0] pc_after, input logic [7:0] imm);
    return pc_after + {{8{imm[7]}}, imm} - 16'd1;
  endfunction

  task automatic check(input string nm, input logic [63:0] a, input logic [63:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", nm, a, e);
    end
  endtask

  task automatic wait_state(input logic [3:0] s, input int max, input string nm);
    int n = 0;
    while (state !== s && n < max) begin
      @(negedge clk);
      n++;
    end
    check(nm, 64'(state), 64'(s));
  endtask

  task automatic begin_reset();
    reset_n    = 1'b0;
    i_ready    = 1'b1;
    d_ready    = 1'b1;
    rf_rp_zero = 1'b0;
    for (int a = 0; a < 65536; a++) imem[a] = 16'h8000;
    @(negedge clk);
  endtask

  task automatic release_reset();
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    vec_t v;
    reset_n = 1'b0;

    vecs.push_back('{16'h3105, 1'b0, 4'd6,  mk(0,0,8'h00,8'h05,2'b10,4'h1,4'h0,4'h0,1,0,0,2'b00,0)});
    vecs.push_back('{16'h0207, 1'b0, 4'd3,  mk(1,0,8'h07,8'h00,2'b01,4'h2,4'h0,4'h0,1,0,0,2'b00,0)});
    vecs.push_back('{16'h1A3C, 1'b0, 4'd4,  mk(0,1,8'h3C,8'h00,2'b00,4'h0,4'hA,4'h0,0,1,0,2'b00,0)});
    vecs.push_back('{16'h2123, 1'b0, 4'd5,  mk(0,0,8'h00,8'h00,2'b00,4'h1,4'h2,4'h3,1,1,1,2'b01,0)});
    vecs.push_back('{16'h4F9E, 1'b0, 4'd7,  mk(0,0,8'h00,8'h00,2'b00,4'hF,4'h9,4'hE,1,1,1,2'b10,0)});
    vecs.push_back('{16'h53FC, 1'b0, 4'd8,  mk(0,0,8'h00,8'h00,2'b00,4'h0,4'h3,4'h0,0,1,0,2'b00,0)});
    vecs.push_back('{16'h6002, 1'b0, 4'd9,  mk(0,0,8'h00,8'h00,2'b00,4'h0,4'h0,4'h0,0,0,0,2'b00,0)});
    vecs.push_back('{16'h7000, 1'b0, 4'd10, mk(0,0,8'h00,8'h00,2'b00,4'h0,4'h0,4'h0,0,0,0,2'b00,1)});

    // Single-instruction table through the scoreboard
    foreach (vecs[i]) begin
      begin_reset();
      imem[0]    = vecs[i].instr;
      rf_rp_zero = vecs[i].zero;
      sb.push_back(vecs[i]);
      release_reset();
      wait_state(vecs[i].st, 8, $sformatf("vec%0d_state", i));
      v = sb.pop_front();
      check($sformatf("vec%0d_outs_%04h", i, v.instr), 64'(act), 64'(v.exp));
    end

    // Reset release and first LDC
    begin_reset();
    imem[0] = 16'h3105;
    check("rst_state", 64'(state), 64'd0);
    check("rst_iaddr", 64'(i_addr), 64'd0);
    check("rst_ird", 64'(i_rd), 64'd0);
    release_reset();
    #1 check("rel_init", 64'(state), 64'd0);
    @(negedge clk);
    check("rel_fetch", 64'({state, i_rd, i_addr}), 64'({4'd1, 1'b1, 16'h0000}));
    @(negedge clk);
    check("rel_decode", 64'({state, i_addr}), 64'({4'd2, 16'h0001}));
    @(negedge clk);
    check("ldc_outs", 64'({state, rf_w_addr, rf_w_data, rf_sel, rf_w_wr, i_addr}),
          64'({4'd6, 4'h1, 8'h05, 2'b10, 1'b1, 16'h0001}));
    @(negedge clk);
    check("ldc_next", 64'({state, i_addr}), 64'({4'd1, 16'h0001}));

    // Fetch stall while i_ready low
    begin_reset();
    imem[0] = 16'h3105;
    i_ready = 1'b0;
    release_reset();
    repeat (4) @(negedge clk);
    check("stall_fetch", 64'({state, i_rd, i_addr}), 64'({4'd1, 1'b1, 16'h0000}));
    i_ready = 1'b1;
    @(negedge clk);
    check("stall_release", 64'(state), 64'd2);

    // LOAD with three wait cycles
    begin_reset();
    imem[0] = 16'h0207;
    d_ready = 1'b0;
    release_reset();
    wait_state(4'd3, 8, "load_enter");
    for (int k = 0; k < 4; k++) begin
      d_ready = (k == 3);
      #1 check($sformatf("load_wait%0d", k), 64'({state, d_rd, d_addr, rf_w_wr}),
               64'({4'd3, 1'b1, 8'h07, (k == 3)}));
      @(negedge clk);
    end
    d_ready = 1'b0;
    check("load_exit", 64'({state, i_addr}), 64'({4'd1, 16'h0001}));

    // JZ taken and not taken at 0x0010
    for (int z = 1; z >= 0; z--) begin
      begin_reset();
      imem[0]    = 16'h6010;
      imem[16]   = 16'h53FC;
      rf_rp_zero = z[0];
      release_reset();
      wait_state(4'd8, 16, $sformatf("jz%0d_enter", z));
      check($sformatf("jz%0d_pc", z), 64'({i_addr, rf_rp_addr, rf_rp_rd}), 64'({16'h0011, 4'h3, 1'b1}));
      @(negedge clk);
      if (z == 1) begin
        check("jz1_jmp", 64'(state), 64'd9);
        @(negedge clk);
        check("jz1_target", 64'({state, i_addr}), 64'({4'd1, jmp_target(16'h0011, 8'hFC)}));
      end else begin
        check("jz0_fetch", 64'({state, i_addr}), 64'({4'd1, 16'h0011}));
      end
    end

    // PC wrap from 0xFFFF
    begin_reset();
    imem[0]     = 16'h60FF;
    imem[65535] = 16'h6002;
    release_reset();
    wait_state(4'd9, 8, "wrap_jmp1");
    @(negedge clk);
    check("wrap_fetch", 64'({state, i_addr}), 64'({4'd1, jmp_target(16'h0001, 8'hFF)}));
    @(negedge clk);
    check("wrap_pc0", 64'({state, i_addr}), 64'({4'd2, 16'h0000}));
    @(negedge clk);
    @(negedge clk);
    check("wrap_target", 64'({state, i_addr}), 64'({4'd1, jmp_target(16'h0000, 8'h02)}));

    // Undefined opcode falls back to fetch
    begin_reset();
    imem[0] = 16'h8123;
    release_reset();
    wait_state(4'd2, 8, "nop_decode");
    @(negedge clk);
    check("nop_fetch", 64'({state, i_addr, act}), 64'({4'd1, 16'h0001, 39'd1}));

    // HALT persists, reset clears it asynchronously
    begin_reset();
    imem[0] = 16'h7000;
    release_reset();
    wait_state(4'd10, 8, "halt_enter");
    begin
      int ok = 0;
      for (int c = 0; c < 20; c++) begin
        @(negedge clk);
        if (state === 4'd10 && halted === 1'b1 && i_rd === 1'b0 && i_addr === 16'h0001) ok++;
      end
      check("halt_hold20", 64'(ok), 64'd20);
    end
    #2 reset_n = 1'b0;
    #1 check("halt_async_clr", 64'({halted, state}), 64'({1'b0, 4'd0}));

    // Reset pulse in the middle of a STORE wait
    begin_reset();
    imem[0] = 16'h1A3C;
    d_ready = 1'b0;
    release_reset();
    wait_state(4'd4, 8, "store_enter");
    repeat (2) @(negedge clk);
    check("store_wait", 64'({d_wr, d_addr, state}), 64'({1'b1, 8'h3C, 4'd4}));
    @(posedge clk);
    #2 reset_n = 1'b0;
    #1 check("store_rst", 64'({d_wr, rf_rp_rd, state, i_addr}), 64'({1'b0, 1'b0, 4'd0, 16'h0000}));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
